// File: rtl/bram_sd_sequencer.sv
// Backup-RAM save/load sequencer: moves sectors between system BRAM and the mounted
// save image over the hps_io sd_* handshake, with dirty tracking and timed auto-save.
module bram_sd_sequencer #(
    parameter int SECTOR_BITS    = 7,
    parameter int SLOT_BITS      = 2,
    parameter int LBA_W          = 32,
    parameter int BUF_AW         = 8,
    parameter int AUTOSAVE_TICKS = 50000000
) (
    input  logic                          clk_sys,
    input  logic                          reset,
    input  logic                          ena,
    input  logic                          load_req,
    input  logic                          save_req,
    input  logic [SLOT_BITS-1:0]          slot,
    input  logic [SECTOR_BITS-1:0]        last_sector,
    input  logic                          autosave_en,
    input  logic                          sys_we,
    output logic [LBA_W-1:0]              sd_lba,
    output logic                          sd_rd,
    output logic                          sd_wr,
    input  logic                          sd_ack,
    input  logic [BUF_AW-1:0]             sd_buff_addr,
    input  logic                          sd_buff_wr,
    output logic [SECTOR_BITS+BUF_AW-1:0] bram_a,
    output logic                          bram_we,
    output logic                          busy,
    output logic                          loading,
    output logic                          dirty,
    output logic                          done,
    output logic                          abort
);
    localparam int CNT_W = (AUTOSAVE_TICKS > 2) ? $clog2(AUTOSAVE_TICKS) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(AUTOSAVE_TICKS - 1);

    typedef enum logic [1:0] {IDLE, REQ, XFER} state_t;

    state_t                 state, state_n;
    logic                   load_prev, save_prev, ack_prev;
    logic [SLOT_BITS-1:0]   slot_l, slot_l_n;
    logic [SECTOR_BITS-1:0] last_l, last_l_n, sector, sector_n;
    logic                   mode_load, mode_load_n;
    logic [LBA_W-1:0]       lba_n;
    logic                   rd_n, wr_n, busy_n, loading_n, dirty_n, done_n, abort_n;
    logic [CNT_W-1:0]       idle_cnt, cnt_n;
    logic                   load_edge, save_edge, ack_rise, ack_fall;
    logic                   autosave_trig, start_load, start_save, load_done;

    assign load_edge = load_req & ~load_prev;
    assign save_edge = save_req & ~save_prev;
    assign ack_rise  = sd_ack & ~ack_prev;
    assign ack_fall  = ~sd_ack & ack_prev;

    // Explicit edges outrank the auto-save, and a load outranks a save.
    assign autosave_trig = (idle_cnt == CNT_MAX) & dirty & autosave_en & ena & (state == IDLE);
    assign start_load    = (state == IDLE) & ena & load_edge;
    assign start_save    = (state == IDLE) & ena & ~load_edge & (save_edge | autosave_trig);

    assign bram_a  = {sector, sd_buff_addr};
    assign bram_we = sd_buff_wr & sd_ack & loading;

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            load_prev <= 1'b0;
            save_prev <= 1'b0;
            ack_prev  <= 1'b0;
            slot_l    <= '0;
            last_l    <= '0;
            sector    <= '0;
            mode_load <= 1'b0;
            sd_lba    <= '0;
            sd_rd     <= 1'b0;
            sd_wr     <= 1'b0;
            busy      <= 1'b0;
            loading   <= 1'b0;
            dirty     <= 1'b0;
            done      <= 1'b0;
            abort     <= 1'b0;
            idle_cnt  <= '0;
        end else begin
            state     <= state_n;
            load_prev <= load_req;
            save_prev <= save_req;
            ack_prev  <= sd_ack;
            slot_l    <= slot_l_n;
            last_l    <= last_l_n;
            sector    <= sector_n;
            mode_load <= mode_load_n;
            sd_lba    <= lba_n;
            sd_rd     <= rd_n;
            sd_wr     <= wr_n;
            busy      <= busy_n;
            loading   <= loading_n;
            dirty     <= dirty_n;
            done      <= done_n;
            abort     <= abort_n;
            idle_cnt  <= cnt_n;
        end
    end

    always_comb begin
        state_n     = state;
        slot_l_n    = slot_l;
        last_l_n    = last_l;
        sector_n    = sector;
        mode_load_n = mode_load;
        lba_n       = sd_lba;
        rd_n        = sd_rd;
        wr_n        = sd_wr;
        busy_n      = busy;
        loading_n   = loading;
        done_n      = 1'b0;
        abort_n     = 1'b0;
        load_done   = 1'b0;
        dirty_n     = dirty;
        cnt_n       = idle_cnt;

        case (state)
            IDLE: begin
                if (start_load || start_save) begin
                    slot_l_n    = slot;
                    last_l_n    = last_sector;
                    mode_load_n = start_load;
                    sector_n    = '0;
                    lba_n       = LBA_W'({slot, sector_n});
                    rd_n        = start_load;
                    wr_n        = start_save;
                    busy_n      = 1'b1;
                    loading_n   = start_load;
                    state_n     = REQ;
                end
            end
            REQ: begin
                if (ack_rise) begin
                    rd_n    = 1'b0;
                    wr_n    = 1'b0;
                    state_n = XFER;
                end
            end
            XFER: begin
                // Loss of the image is only acted on once the sector in flight has finished.
                if (ack_fall) begin
                    if (!ena) begin
                        abort_n   = 1'b1;
                        busy_n    = 1'b0;
                        loading_n = 1'b0;
                        state_n   = IDLE;
                    end else if (sector == last_l) begin
                        done_n    = 1'b1;
                        load_done = mode_load;
                        busy_n    = 1'b0;
                        loading_n = 1'b0;
                        state_n   = IDLE;
                    end else begin
                        sector_n = sector + SECTOR_BITS'(1);
                        lba_n    = LBA_W'({slot_l, sector_n});
                        rd_n     = mode_load;
                        wr_n     = ~mode_load;
                        state_n  = REQ;
                    end
                end
            end
            default: state_n = IDLE;
        endcase

        // A write landing in the save-start cycle must keep the image marked dirty.
        if (start_save || load_done) dirty_n = 1'b0;
        if (sys_we && !loading)      dirty_n = 1'b1;

        if (sys_we || busy || start_save || start_load) cnt_n = '0;
        else if (idle_cnt != CNT_MAX)                   cnt_n = idle_cnt + CNT_W'(1);
    end
endmodule
